alu_exec_unit: RTL and testbench

- Parametrised, handshaked ALU execution unit for the datapath.
- Decodes the existing opcode/opext encoding, selects the operand (register or immediate), and computes the result and PSR flags.
- Single-cycle ops complete in one cycle. Shift ops use an iterative 1-bit/cycle shifter.
- Sits between the decode/register-read stage and writeback.

---
 rtl/alu_exec_unit.sv | 206 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit - handshaked ALU execution unit between register-read and writeback.
//
// Decodes opcode/opext, picks operand B (register or immediate), and produces the
// result plus PSR flags. Logic ops and add/sub/cmp/mov/lui finish in one cycle.
// Shifts use an iterative 1-bit-per-cycle shifter.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   in_valid / in_ready   request handshake
//   opcode, opext         instruction encoding
//   src, dst, imm         Rsrc (also the lsh amount), Rdst, 8-bit immediate
//   out_valid / out_ready result handshake
//   result, wb_en         value to write and its Rdst write enable
//   flags, flags_we       {N,Z,F,L,C} and PSR write enable
//   illegal               undecodable opcode/opext
module alu_exec_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [3:0]       opext,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  input  logic [7:0]       imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wb_en,
  output logic [4:0]       flags,
  output logic             flags_we,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;

  // R-type ops reuse the I-type opcode values in opext, so one key decodes both.
  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_LUI  = 4'b1111;
  localparam logic [3:0] OP_SH   = 4'b1000;
  localparam logic [3:0] EXT_LSH = 4'b0100;

  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_MAX = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] result_reg;
  logic             wb_en_reg, flags_we_reg, illegal_reg;
  logic [4:0]       flags_reg;
  logic [SHW:0]     count_reg;   // shifts still to perform after the current one
  logic             left_reg;

  logic             accept;
  logic             is_r, is_shift;
  logic [3:0]       key;
  logic [WIDTH-1:0] imm_s, imm_z, opb, alu_res, first_shift;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [4:0]       alu_flags;
  logic             alu_wb, alu_fwe, alu_ill;
  logic [SHW:0]     amt, amt_mag, amt_cnt;

  // Decode, operand select and single-cycle ALU.
  always_comb begin
    is_r     = (opcode == OP_R);
    key      = is_r ? opext : opcode;
    is_shift = (opcode == OP_SH);
    imm_s    = {{(WIDTH-8){imm[7]}}, imm};
    imm_z    = {{(WIDTH-8){1'b0}}, imm};

    if (is_r)
      opb = src;
    else if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_CMP)
      opb = imm_s;
    else
      opb = imm_z;

    sum_ext  = {1'b0, dst} + {1'b0, opb};
    diff_ext = {1'b0, dst} - {1'b0, opb};   // top bit is the unsigned borrow

    alu_res   = '0;
    alu_flags = '0;
    alu_wb    = 1'b0;
    alu_fwe   = 1'b0;
    alu_ill   = 1'b1;
    case (key)
      OP_ADD: begin
        alu_res      = sum_ext[MSB:0];
        alu_flags[0] = sum_ext[WIDTH];
        alu_flags[2] = (dst[MSB] == opb[MSB]) && (sum_ext[MSB] != dst[MSB]);
        alu_wb = 1'b1; alu_fwe = 1'b1; alu_ill = 1'b0;
      end
      OP_SUB: begin
        alu_res      = diff_ext[MSB:0];
        alu_flags[0] = diff_ext[WIDTH];
        alu_flags[2] = (dst[MSB] != opb[MSB]) && (diff_ext[MSB] != dst[MSB]);
        alu_wb = 1'b1; alu_fwe = 1'b1; alu_ill = 1'b0;
      end
      OP_CMP: begin
        alu_res      = diff_ext[MSB:0];
        alu_flags[4] = $signed(dst) < $signed(opb);
        alu_flags[3] = (dst == opb);
        alu_flags[1] = diff_ext[WIDTH];
        alu_fwe = 1'b1; alu_ill = 1'b0;
      end
      OP_AND: begin alu_res = dst & opb; alu_wb = 1'b1; alu_ill = 1'b0; end
      OP_XOR: begin alu_res = dst ^ opb; alu_wb = 1'b1; alu_ill = 1'b0; end
      OP_OR:  begin alu_res = dst | opb; alu_wb = 1'b1; alu_ill = 1'b0; end
      OP_MOV: begin alu_res = opb;       alu_wb = 1'b1; alu_ill = 1'b0; end
      OP_LUI: begin
        if (!is_r) begin
          alu_res[15:0] = {imm, 8'h00};
          alu_wb = 1'b1; alu_ill = 1'b0;
        end
      end
      default: ;
    endcase

    // Shift amount is a two's-complement SHW+1 bit field; the cycle count is
    // clamped to WIDTH since zero-fill has emptied the word by then.
    amt         = (opext == EXT_LSH) ? src[SHW:0] : imm_s[SHW:0];
    amt_mag     = amt[SHW] ? (~amt + CNT_ONE) : amt;
    amt_cnt     = (amt_mag > CNT_MAX) ? CNT_MAX : amt_mag;
    first_shift = amt[SHW] ? (dst >> 1) : (dst << 1);
  end

  // The accept edge already performs the first shift bit, so a shift of n
  // presents its result n cycles after accept, the same as a single-cycle op for n=1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE:  in_ready = 1'b1;
      SHIFT: if (count_reg == CNT_ONE) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (in_valid && in_ready)
      state_next = (is_shift && amt_cnt > CNT_ONE) ? SHIFT : DONE;
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      result_reg   <= '0;
      wb_en_reg    <= 1'b0;
      flags_reg    <= '0;
      flags_we_reg <= 1'b0;
      illegal_reg  <= 1'b0;
      count_reg    <= '0;
      left_reg     <= 1'b0;
    end else if (accept) begin
      if (is_shift) begin
        result_reg   <= (amt_cnt == '0) ? dst : first_shift;
        count_reg    <= amt_cnt - CNT_ONE;
        left_reg     <= ~amt[SHW];
        wb_en_reg    <= 1'b1;
        flags_reg    <= '0;
        flags_we_reg <= 1'b0;
        illegal_reg  <= 1'b0;
      end else begin
        result_reg   <= alu_res;
        wb_en_reg    <= alu_wb;
        flags_reg    <= alu_flags;
        flags_we_reg <= alu_fwe;
        illegal_reg  <= alu_ill;
      end
    end else if (state_reg == SHIFT) begin
      result_reg <= left_reg ? (result_reg << 1) : (result_reg >> 1);
      count_reg  <= count_reg - CNT_ONE;
    end
  end

  assign result   = result_reg;
  assign wb_en    = wb_en_reg;
  assign flags    = flags_reg;
  assign flags_we = flags_we_reg;
  assign illegal  = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: expected results are queued when a request
// is accepted and compared when the unit hands the result over.
module tb_alu_exec_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   opcode, opext;
  logic [W-1:0] src, dst, result;
  logic [7:0]   imm;
  logic         wb_en, flags_we, illegal;
  logic [4:0]   flags;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         res_care;
    logic         wb;
    logic [4:0]   fl;
    logic         fwe;
    logic         ill;
    int           lat;
    int           acc;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .opext(opext), .src(src), .dst(dst), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .wb_en(wb_en), .flags(flags), .flags_we(flags_we), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called in the low clock phase; returns just after the negedge following accept.
  task automatic send(input string tag, input logic [3:0] op, input logic [3:0] ext,
                      input logic [W-1:0] s, input logic [W-1:0] d, input logic [7:0] im,
                      input logic [W-1:0] r, input logic rc, input logic wb,
                      input logic [4:0] fl, input logic fwe, input logic ill, input int lat);
    exp_t e;
    int k;
    opcode = op; opext = ext; src = s; dst = d; imm = im; in_valid = 1'b1;
    #1;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      check({tag, "_accept"}, 32'(in_ready), 32'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    e.res = r; e.res_care = rc; e.wb = wb; e.fl = fl; e.fwe = fwe; e.ill = ill;
    e.lat = lat; e.acc = cyc;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() > 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("drain", 32'(sb_q.size()), 32'(0));
    #1;
  endtask

  // Monitor: samples late in the low phase, after stimulus has settled.
  initial begin
    exp_t  e;
    string t;
    bit    fresh;
    fresh = 1'b1;
    forever begin
      @(negedge clk); #3;
      if (sb_q.size() == 0) begin
        check("idle_valid", 32'(out_valid), 32'(0));
      end else if (!out_valid) begin
        check("busy_ready", 32'(in_ready), 32'(0));
      end else begin
        if (fresh) begin
          check({tag_q[0], "_lat"}, 32'(cyc - sb_q[0].acc + 1), 32'(sb_q[0].lat));
          fresh = 1'b0;
        end
        check("done_ready", 32'(in_ready), 32'(out_ready));
        if (out_ready) begin
          e = sb_q.pop_front();
          t = tag_q.pop_front();
          if (e.res_care) check({t, "_result"}, 32'(result), 32'(e.res));
          check({t, "_wb_en"},    32'(wb_en),    32'(e.wb));
          check({t, "_flags"},    32'(flags),    32'(e.fl));
          check({t, "_flags_we"}, 32'(flags_we), 32'(e.fwe));
          check({t, "_illegal"},  32'(illegal),  32'(e.ill));
          $display("txn %-10s result=%h wb_en=%b flags=%b flags_we=%b illegal=%b",
                   t, result, wb_en, flags, flags_we, illegal);
          fresh = 1'b1;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held low with a valid add pending; nothing may be accepted.
    reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    opcode = 4'b0000; opext = 4'b0101; dst = 16'h7FFF; src = 16'h0001; imm = 8'h00;
    repeat (2) begin
      @(negedge clk); #1;
      check("rst_in_ready",  32'(in_ready),  32'(1));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_result",    32'(result),    32'(0));
      check("rst_ctl",       32'({wb_en, flags, flags_we, illegal}), 32'(0));
    end
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk); #1;
    check("post_rst_valid", 32'(out_valid), 32'(0));

    //   tag          op       ext      src       dst       imm    result  rc wb flags     fwe ill lat
    send("add",     4'b0000, 4'b0101, 16'h0001, 16'h7FFF, 8'h00, 16'h8000, 1, 1, 5'b00100, 1, 0, 1);
    send("addi",    4'b0101, 4'b0000, 16'h0000, 16'hFFFF, 8'h01, 16'h0000, 1, 1, 5'b00001, 1, 0, 1);
    send("addi_neg",4'b0101, 4'b0000, 16'h0000, 16'h0010, 8'hF0, 16'h0000, 1, 1, 5'b00001, 1, 0, 1);
    send("cmpi",    4'b1011, 4'b0000, 16'h0000, 16'h0005, 8'hFF, 16'h0000, 0, 0, 5'b00010, 1, 0, 1);
    send("sub",     4'b0000, 4'b1001, 16'h0005, 16'h0003, 8'h00, 16'hFFFE, 1, 1, 5'b00001, 1, 0, 1);
    send("subi_ov", 4'b1001, 4'b0000, 16'h0000, 16'h8000, 8'h01, 16'h7FFF, 1, 1, 5'b00100, 1, 0, 1);
    send("cmp_neg", 4'b0000, 4'b1011, 16'h0001, 16'h8000, 8'h00, 16'h0000, 0, 0, 5'b10000, 1, 0, 1);
    send("cmp_eq",  4'b0000, 4'b1011, 16'h1234, 16'h1234, 8'h00, 16'h0000, 0, 0, 5'b01000, 1, 0, 1);
    send("andi",    4'b0001, 4'b0000, 16'h0000, 16'hF0F0, 8'h8F, 16'h0080, 1, 1, 5'b00000, 0, 0, 1);
    send("ori",     4'b0010, 4'b0000, 16'h0000, 16'h1200, 8'h34, 16'h1234, 1, 1, 5'b00000, 0, 0, 1);
    send("lui",     4'b1111, 4'b0000, 16'h0000, 16'h5555, 8'hAB, 16'hAB00, 1, 1, 5'b00000, 0, 0, 1);
    send("mov",     4'b0000, 4'b1101, 16'hBEEF, 16'h1111, 8'h00, 16'hBEEF, 1, 1, 5'b00000, 0, 0, 1);
    send("or",      4'b0000, 4'b0010, 16'h0F00, 16'h00F0, 8'h00, 16'h0FF0, 1, 1, 5'b00000, 0, 0, 1);
    send("and",     4'b0000, 4'b0001, 16'h0FF0, 16'hFF00, 8'h00, 16'h0F00, 1, 1, 5'b00000, 0, 0, 1);
    send("xor",     4'b0000, 4'b0011, 16'hFFFF, 16'h5555, 8'h00, 16'hAAAA, 1, 1, 5'b00000, 0, 0, 1);
    send("lshi3",   4'b1000, 4'b0000, 16'h001C, 16'h0001, 8'h03, 16'h0008, 1, 1, 5'b00000, 0, 0, 3);
    send("lsh_m4",  4'b1000, 4'b0100, 16'h001C, 16'h8000, 8'h03, 16'h0800, 1, 1, 5'b00000, 0, 0, 4);
    send("lshi_ext",4'b1000, 4'b0011, 16'h001C, 16'h0003, 8'h02, 16'h000C, 1, 1, 5'b00000, 0, 0, 2);
    send("lsh0",    4'b1000, 4'b0100, 16'h0000, 16'h1234, 8'h05, 16'h1234, 1, 1, 5'b00000, 0, 0, 1);
    send("lsh15",   4'b1000, 4'b0100, 16'h000F, 16'h0001, 8'h00, 16'h8000, 1, 1, 5'b00000, 0, 0, 15);
    send("lshi_m1", 4'b1000, 4'b0000, 16'h0000, 16'h8001, 8'h1F, 16'h4000, 1, 1, 5'b00000, 0, 0, 1);
    send("lshi_m16",4'b1000, 4'b0000, 16'h0000, 16'hFFFF, 8'h10, 16'h0000, 1, 1, 5'b00000, 0, 0, 16);
    drain();

    // Output stall: result held and no new request taken while out_ready is low.
    out_ready = 1'b0;
    send("xori",    4'b0011, 4'b0000, 16'h0000, 16'hFFFF, 8'hFF, 16'hFF00, 1, 1, 5'b00000, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid",  32'(out_valid), 32'(1));
      check("stall_ready",  32'(in_ready),  32'(0));
      check("stall_result", 32'(result),    32'(16'hFF00));
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    send("movi",    4'b1101, 4'b0000, 16'h0000, 16'h0000, 8'h80, 16'h0080, 1, 1, 5'b00000, 0, 0, 1);
    send("ill_r8",  4'b0000, 4'b1000, 16'h1234, 16'h5678, 8'h00, 16'h0000, 1, 0, 5'b00000, 0, 1, 1);
    send("ill_op4", 4'b0100, 4'b0000, 16'h1234, 16'h5678, 8'h12, 16'h0000, 1, 0, 5'b00000, 0, 1, 1);
    drain();

    // Reset three cycles into a 7-bit shift: the shift is dropped.
    @(negedge clk); #1;
    opcode = 4'b1000; opext = 4'b0000; dst = 16'h00FF; imm = 8'h07; in_valid = 1'b1;
    #1;
    check("abort_accept_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("abort_shift_ready", 32'(in_ready), 32'(0));
    reset = 1'b0;
    @(negedge clk); #1;
    check("abort_rst_valid",   32'(out_valid), 32'(0));
    check("abort_rst_ready",   32'(in_ready),  32'(1));
    check("abort_rst_result",  32'(result),    32'(0));
    check("abort_rst_illegal", 32'(illegal),   32'(0));
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      check("abort_no_valid", 32'(out_valid), 32'(0));
    end

    send("ill_rf",  4'b0000, 4'b1111, 16'h1234, 16'h5678, 8'hAB, 16'h0000, 1, 0, 5'b00000, 0, 1, 1);
    send("ill_r4",  4'b0000, 4'b0100, 16'h0003, 16'h5678, 8'h00, 16'h0000, 1, 0, 5'b00000, 0, 1, 1);
    drain();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
